// File: rtl/latch_load_sequencer_if.sv
// rtl/latch_load_sequencer_if.sv - board controls in, latch drive out
interface latch_load_sequencer_if;
  logic Sw;
  logic Btn;
  logic D;
  logic En;
  logic Busy;

  modport master (output Sw, Btn, input D, En, Busy);
  modport slave  (input Sw, Btn, output D, En, Busy);
endinterface

// File: rtl/latch_load_sequencer.sv
// rtl/latch_load_sequencer.sv - debounced switch/button to timed D/En load sequence for a gated D latch
module latch_load_sequencer #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20,
  parameter int SETUP_CYCLES    = 4,
  parameter int EN_WIDTH        = 8,
  parameter int HOLD_CYCLES     = 4
) (
  input  logic                   Clk,
  input  logic                   Rst_n,
  latch_load_sequencer_if.slave  bus
);

  localparam int TIMER_MAX =
    (SETUP_CYCLES > EN_WIDTH)
      ? ((SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES)
      : ((EN_WIDTH > HOLD_CYCLES) ? EN_WIDTH : HOLD_CYCLES);
  localparam int TW = $clog2(TIMER_MAX + 1);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0]    T_SETUP = TW'(SETUP_CYCLES - 1);
  localparam logic [TW-1:0]    T_EN    = TW'(EN_WIDTH - 1);
  localparam logic [TW-1:0]    T_HOLD  = TW'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SETUP    = 3'd1,
    PULSE    = 3'd2,
    HOLD     = 3'd3,
    WAIT_REL = 3'd4
  } state_t;

  logic             sw_m_q,  sw_m_d,  sw_s_q,  sw_s_d;
  logic             btn_m_q, btn_m_d, btn_s_q, btn_s_d;
  logic             sw_db_q,  sw_db_d,  btn_db_q,  btn_db_d;
  logic [CNT_W-1:0] sw_cnt_q, sw_cnt_d, btn_cnt_q, btn_cnt_d;
  state_t           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             d_q, d_d, en_q, en_d, busy_q, busy_d;

  // Returns {new debounced value, new counter}.
  function automatic logic [CNT_W:0] debounce_next(input logic s, input logic db,
                                                    input logic [CNT_W-1:0] cnt);
    if (s == db)
      return {db, {CNT_W{1'b0}}};
    else if (cnt == DB_LAST)
      return {s, {CNT_W{1'b0}}};
    else
      return {db, cnt + CNT_W'(1)};
  endfunction

  always_comb begin
    sw_m_d  = bus.Sw;
    sw_s_d  = sw_m_q;
    btn_m_d = bus.Btn;
    btn_s_d = btn_m_q;
    {sw_db_d,  sw_cnt_d}  = debounce_next(sw_s_q,  sw_db_q,  sw_cnt_q);
    {btn_db_d, btn_cnt_d} = debounce_next(btn_s_q, btn_db_q, btn_cnt_q);
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q + TW'(1);
    d_d     = d_q;
    en_d    = en_q;
    case (state_q)
      IDLE: begin
        timer_d = '0;
        en_d    = 1'b0;
        if (btn_db_q) begin
          d_d     = sw_db_q;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (timer_q == T_SETUP) begin
          state_d = PULSE;
          en_d    = 1'b1;
          timer_d = '0;
        end
      end
      PULSE: begin
        if (timer_q == T_EN) begin
          state_d = HOLD;
          en_d    = 1'b0;
          timer_d = '0;
        end
      end
      HOLD: begin
        if (timer_q == T_HOLD) begin
          state_d = WAIT_REL;
          timer_d = '0;
        end
      end
      WAIT_REL: begin
        timer_d = '0;
        // A held button must be released before another sequence can start.
        if (!btn_db_q)
          state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
        en_d    = 1'b0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      sw_m_q    <= 1'b0;
      sw_s_q    <= 1'b0;
      btn_m_q   <= 1'b0;
      btn_s_q   <= 1'b0;
      sw_db_q   <= 1'b0;
      btn_db_q  <= 1'b0;
      sw_cnt_q  <= '0;
      btn_cnt_q <= '0;
      state_q   <= IDLE;
      timer_q   <= '0;
      d_q       <= 1'b0;
      en_q      <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      sw_m_q    <= sw_m_d;
      sw_s_q    <= sw_s_d;
      btn_m_q   <= btn_m_d;
      btn_s_q   <= btn_s_d;
      sw_db_q   <= sw_db_d;
      btn_db_q  <= btn_db_d;
      sw_cnt_q  <= sw_cnt_d;
      btn_cnt_q <= btn_cnt_d;
      state_q   <= state_d;
      timer_q   <= timer_d;
      d_q       <= d_d;
      en_q      <= en_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.D    = d_q;
  assign bus.En   = en_q;
  assign bus.Busy = busy_q;

endmodule

// File: tb/tb_latch_load_sequencer.sv
// tb/tb_latch_load_sequencer.sv - vector table, hand sequences and randomized reference-model checks
module tb_latch_load_sequencer;

  localparam int DEB = 4;
  localparam int CW  = 3;
  localparam int SET = 2;
  localparam int ENW = 3;
  localparam int HLD = 2;

  logic Clk   = 1'b0;
  logic Rst_n = 1'b0;

  latch_load_sequencer_if bus();

  latch_load_sequencer #(
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W          (CW),
    .SETUP_CYCLES   (SET),
    .EN_WIDTH       (ENW),
    .HOLD_CYCLES    (HLD)
  ) dut (
    .Clk  (Clk),
    .Rst_n(Rst_n),
    .bus  (bus.slave)
  );

  always #5 Clk = ~Clk;

  int checks   = 0;
  int failures = 0;
  int en_rises = 0;

  always @(posedge bus.En) en_rises++;

  // Reference model: raw samples per edge since reset, debounced level flips
  // once the last DEB synchronised samples all disagree with it, and the
  // load sequence is timed as an offset from the edge that updated D.
  bit sw_h[$];
  bit btn_h[$];
  bit m_sw_db, m_btn_db, m_d, m_en, m_busy, m_rel;
  int m_start;

  function automatic bit raw_at(input bit sel, input int k);
    if (k < 1) return 1'b0;
    return sel ? btn_h[k-1] : sw_h[k-1];
  endfunction

  function automatic bit settled(input bit sel, input bit db, input int t);
    for (int j = 2; j <= DEB + 1; j++)
      if (raw_at(sel, t - j) == db) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge Clk or negedge Rst_n) begin : model
    bit sdb, bdb;
    int t, k;
    if (!Rst_n) begin
      sw_h.delete();
      btn_h.delete();
      m_sw_db = 0; m_btn_db = 0; m_d = 0; m_en = 0; m_busy = 0; m_rel = 0;
      m_start = 0;
    end else begin
      sdb = m_sw_db;
      bdb = m_btn_db;
      sw_h.push_back(bus.Sw);
      btn_h.push_back(bus.Btn);
      t = sw_h.size();
      if (settled(1'b0, sdb, t)) m_sw_db = ~sdb;
      if (settled(1'b1, bdb, t)) m_btn_db = ~bdb;
      if (!m_busy) begin
        if (bdb) begin
          m_busy  = 1'b1;
          m_d     = sdb;
          m_start = t;
        end
      end else if (!m_rel) begin
        k    = t - m_start;
        m_en = (k >= SET) && (k < SET + ENW);
        if (k == SET + ENW + HLD) m_rel = 1'b1;
      end else if (!bdb) begin
        m_busy = 1'b0;
        m_rel  = 1'b0;
      end
    end
  end

  function automatic logic [2:0] outs();
    return {bus.D, bus.En, bus.Busy};
  endfunction

  task automatic cmp(input string name, input logic [2:0] got, input logic [2:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got D,En,Busy=%b expected %b", name, $time, got, exp);
    end
  endtask

  task automatic cmp_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge Clk);
      cmp("model", outs(), {m_d, m_en, m_busy});
    end
  endtask

  typedef struct {
    bit         rst_n;
    bit         sw;
    bit         btn;
    int         ncyc;
    logic [2:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkv(input bit r, input bit s, input bit b, input int n,
                               input logic [2:0] e);
    vec_t v;
    v.rst_n = r; v.sw = s; v.btn = b; v.ncyc = n; v.exp = e;
    return v;
  endfunction

  initial begin
    int r0;
    int sw_run, btn_run;

    // Basic load, then button glitch, then switch chatter.
    vecs.push_back(mkv(1, 1, 0, 10, 3'b000));
    vecs.push_back(mkv(1, 1, 1,  6, 3'b000));
    vecs.push_back(mkv(1, 1, 1,  1, 3'b101));
    vecs.push_back(mkv(1, 1, 1,  1, 3'b101));
    vecs.push_back(mkv(1, 1, 1,  1, 3'b111));
    vecs.push_back(mkv(1, 1, 1,  2, 3'b111));
    vecs.push_back(mkv(1, 1, 1,  1, 3'b101));
    vecs.push_back(mkv(1, 1, 1, 18, 3'b101));
    vecs.push_back(mkv(1, 1, 0,  6, 3'b101));
    vecs.push_back(mkv(1, 1, 0,  1, 3'b100));
    vecs.push_back(mkv(1, 1, 1,  3, 3'b100));
    vecs.push_back(mkv(1, 1, 0, 10, 3'b100));
    for (int i = 0; i < 5; i++) begin
      vecs.push_back(mkv(1, 0, 0, 2, 3'b100));
      vecs.push_back(mkv(1, 1, 0, 2, 3'b100));
    end
    vecs.push_back(mkv(1, 1, 0, 6, 3'b100));

    bus.Sw  = 1'b0;
    bus.Btn = 1'b0;
    repeat (2) @(negedge Clk);
    cmp("reset_state", outs(), 3'b000);

    r0 = en_rises;
    foreach (vecs[i]) begin
      Rst_n   = vecs[i].rst_n;
      bus.Sw  = vecs[i].sw;
      bus.Btn = vecs[i].btn;
      step(vecs[i].ncyc);
      cmp($sformatf("vec%0d", i), outs(), vecs[i].exp);
    end
    cmp_int("basic_pulse_count", en_rises - r0, 1);

    // Data stability: Sw drops during PULSE, D keeps the sampled 1.
    bus.Btn = 1'b1;
    step(8);  cmp("stab_setup", outs(), 3'b101);
    step(1);  cmp("stab_pulse", outs(), 3'b111);
    bus.Sw = 1'b0;
    step(2);  cmp("stab_pulse_end", outs(), 3'b111);
    step(1);  cmp("stab_hold", outs(), 3'b101);
    step(8);  cmp("stab_wait_rel", outs(), 3'b101);
    bus.Btn = 1'b0;
    step(7);  cmp("stab_idle", outs(), 3'b100);

    // Next press samples the now-debounced Sw=0; a short release in PULSE is absorbed.
    r0 = en_rises;
    bus.Btn = 1'b1;
    step(6);  cmp("press2_before", outs(), 3'b100);
    step(1);  cmp("press2_d0", outs(), 3'b001);
    step(2);  cmp("press2_pulse", outs(), 3'b011);
    bus.Btn = 1'b0;
    step(3);
    bus.Btn = 1'b1;
    step(10); cmp("repress_wait_rel", outs(), 3'b001);
    cmp_int("repress_pulse_count", en_rises - r0, 1);
    bus.Btn = 1'b0;
    step(7);  cmp("repress_idle", outs(), 3'b000);

    r0 = en_rises;
    bus.Btn = 1'b1;
    step(9);  cmp("press3_pulse", outs(), 3'b011);
    cmp_int("press3_pulse_count", en_rises - r0, 1);

    // Asynchronous reset in the middle of the pulse.
    #2 Rst_n = 1'b0;
    #1 cmp("async_reset", outs(), 3'b000);
    @(negedge Clk);
    bus.Btn = 1'b0;
    Rst_n   = 1'b1;
    r0 = en_rises;
    step(10); cmp("after_reset_idle", outs(), 3'b000);
    cmp_int("after_reset_pulses", en_rises - r0, 0);

    sw_run  = 0;
    btn_run = 0;
    for (int i = 0; i < 3000; i++) begin
      if (sw_run == 0) begin
        bus.Sw = 1'($urandom_range(0, 1));
        sw_run = $urandom_range(1, 12);
      end
      if (btn_run == 0) begin
        bus.Btn = 1'($urandom_range(0, 1));
        btn_run = $urandom_range(1, 20);
      end
      sw_run--;
      btn_run--;
      step(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/latch_load_sequencer.md
Name: latch_load_sequencer

Overview:
- Upstream stage for the NAND-gate gated D latch: drives its D and En inputs from raw Basys3 board controls.
- Synchronises and debounces one slide switch (data) and one push button (load command).
- Each debounced button press produces one cleanly timed load sequence:
  - D is set up before En rises.
  - En is held high for a fixed pulse.
  - D is held stable after En falls.
- Guarantees the latch never sees D change while En is high.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive cycles a synchronised input must differ from its debounced value before the debounced value follows (10 ms at 100 MHz); must be >= 1.
- CNT_W, 20, width of each debounce counter; must satisfy 2^CNT_W >= DEBOUNCE_CYCLES.
- SETUP_CYCLES, 4, cycles D is stable with En low before En rises; >= 1.
- EN_WIDTH, 8, cycles En is high; >= 1.
- HOLD_CYCLES, 4, cycles D is held with En low after En falls; >= 1.

Ports:
- Clk, input, 1, system clock (100 MHz on board).
- Rst_n, input, 1, asynchronous active-low reset.
- Sw, input, 1, raw asynchronous slide switch (latch data source).
- Btn, input, 1, raw asynchronous push button (load command, active high).
- D, output, 1, registered data to latch D.
- En, output, 1, registered enable to latch En.
- Busy, output, 1, high whenever the FSM is not in IDLE.

Behaviour:
- Reset (Rst_n low, asynchronous): D=0, En=0, Busy=0, FSM=IDLE. All synchroniser flops, debounced values and counters are cleared to 0.
- Reset asserted mid-sequence: En drops to 0 immediately without waiting for a clock edge; no partial pulse resumes after release.
- Synchroniser: Sw and Btn each pass through two flops. The second-stage outputs are sw_s and btn_s.
- Debouncer, per input (x_s, x_db, x_cnt):
  - If x_s == x_db: x_cnt <= 0.
  - Else if x_cnt == DEBOUNCE_CYCLES-1: x_db <= x_s and x_cnt <= 0.
  - Else: x_cnt <= x_cnt+1.
  - Any glitch shorter than DEBOUNCE_CYCLES consecutive cycles is ignored.
  - Latency from first sampling edge to x_db change is DEBOUNCE_CYCLES+2 edges.
- FSM (all outputs registered):
  - IDLE: En=0, Busy=0. On an edge with btn_db==1: D <= sw_db, timer <= 0, go to SETUP.
  - SETUP: En=0. After SETUP_CYCLES cycles in the state, go to PULSE; En <= 1 on that same edge.
  - PULSE: En=1 for exactly EN_WIDTH cycles. Then En <= 0 and go to HOLD.
  - HOLD: En=0. After exactly HOLD_CYCLES cycles, go to WAIT_REL.
  - WAIT_REL: En=0. Wait for btn_db==0, then go to IDLE.
- A button held down therefore produces exactly one load sequence.
- Button held high through reset release counts as a press once it has debounced.
- D is written only on the IDLE->SETUP transition; it is constant in every other state regardless of Sw.
- Switch changes during a sequence are not queued. The next press samples the sw_db value current at that time.
- Button presses arriving during SETUP, PULSE or HOLD are absorbed; no second sequence is started.
- Busy=1 in SETUP, PULSE, HOLD and WAIT_REL.
- Minimum sequence length from D update to IDLE is SETUP_CYCLES+EN_WIDTH+HOLD_CYCLES+1 cycles.
- Single shared timer, sized to hold max(SETUP_CYCLES, EN_WIDTH, HOLD_CYCLES); cleared on every state change.

Test Plan (DEBOUNCE_CYCLES=4, CNT_W=3, SETUP_CYCLES=2, EN_WIDTH=3, HOLD_CYCLES=2):
- Basic load: Sw=1 stable, Btn rises and stays high for 30 cycles.
  - D goes 0->1 exactly 7 edges after the first sampling edge.
  - En=0 for the next 2 cycles, then En=1 for exactly 3 cycles, then En=0.
  - Busy stays 1 until 1 cycle after btn_db falls.
  - Exactly one En pulse.
- Glitch rejection: Btn high for 3 cycles, then low. Separately, Sw toggles every 2 cycles for 20 cycles.
  - En never rises.
  - sw_db and D are unchanged.
- Data stability: start a load with Sw=1, then set Sw=0 during PULSE.
  - D stays 1 through PULSE, HOLD and WAIT_REL.
  - The next press (after Sw has debounced) sets D=0.
- Re-press absorption: release and re-press Btn (each phase >4 cycles) while in PULSE/HOLD.
  - Only the first sequence's single En pulse occurs.
  - A press after return to IDLE produces one new pulse.
- Async reset: assert Rst_n=0 mid-cycle during PULSE.
  - En=0, D=0 and Busy=0 within the same cycle, with no clock edge required.
  - After release with Btn low, outputs stay 0 and the FSM stays in IDLE.
